// File: rtl/vga_clk_pkg.sv
// Shared types and sizing helpers for the fractional clock-enable generator.
package vga_clk_pkg;

   typedef enum logic [1:0] {
      LOCKING = 2'd0,
      LOCKED  = 2'd1,
      APPLY   = 2'd2
   } state_t;

   function automatic int chw(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Half of full scale: divide-by-2 enable rate out of reset.
   function automatic logic [63:0] default_inc(input int acc_w);
      return 64'd1 << (acc_w - 1);
   endfunction

endpackage

// File: rtl/vga_nco_ch.sv
// One NCO channel: phase accumulator with a load port, registered carry strobe and MSB.
module vga_nco_ch
   import vga_clk_pkg::*;
#(
   parameter int               ACC_W       = 16,
   parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(default_inc(ACC_W))
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [ACC_W-1:0] load_inc,
   input  logic [ACC_W-1:0] load_phase,
   output logic             strobe,
   output logic             msb
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc;
   logic [ACC_W:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, inc};

   // A zero increment leaves sum == acc, so the channel freezes on its own.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         inc    <= DEFAULT_INC;
         strobe <= 1'b0;
         msb    <= 1'b0;
      end else if (load) begin
         acc    <= load_phase;
         inc    <= load_inc;
         strobe <= 1'b0;
         msb    <= load_phase[ACC_W-1];
      end else begin
         acc    <= sum[ACC_W-1:0];
         strobe <= sum[ACC_W];
         msb    <= sum[ACC_W-1];
      end
   end

endmodule

// File: rtl/vga_clk_ena_gen.sv
// Multi-channel fractional clock-enable generator: NCO channels plus the lock/config sequencer.
//
// state   | meaning
// LOCKING | settle countdown running, locked and cfg_ready low
// LOCKED  | stable, config requests accepted
// APPLY   | latched config written into the addressed channel
module vga_clk_ena_gen
   import vga_clk_pkg::*;
#(
   parameter int               NUM_CH      = 2,
   parameter int               ACC_W       = 16,
   parameter int               LOCK_CYCLES = 16,
   parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(default_inc(ACC_W)),
   localparam int              CHW         = chw(NUM_CH)
)(
   input  logic              refclk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CHW-1:0]    cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   input  logic [ACC_W-1:0]  cfg_phase,
   output logic [NUM_CH-1:0] outclk_en,
   output logic [NUM_CH-1:0] outclk,
   output logic              locked
);

   localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
   logic             locked_nxt;
   logic             ready_nxt;
   logic             latch_en;
   logic             apply;
   logic             ch_ok;
   logic [CHW-1:0]   lat_ch;
   logic [ACC_W-1:0] lat_inc;
   logic [ACC_W-1:0] lat_phase;

   assign ch_ok = int'(cfg_ch) < NUM_CH;

   always_comb begin
      state_nxt    = state;
      lock_cnt_nxt = lock_cnt;
      locked_nxt   = locked;
      ready_nxt    = cfg_ready;
      latch_en     = 1'b0;
      apply        = 1'b0;
      case (state)
         LOCKING: begin
            if (lock_cnt == '0) begin
               state_nxt  = LOCKED;
               locked_nxt = 1'b1;
               ready_nxt  = 1'b1;
            end else begin
               lock_cnt_nxt = lock_cnt - CNT_W'(1);
            end
         end
         LOCKED: begin
            if (cfg_valid && cfg_ready) begin
               ready_nxt = 1'b0;
               if (ch_ok) begin
                  latch_en   = 1'b1;
                  locked_nxt = 1'b0;
                  state_nxt  = APPLY;
               end
            end else begin
               ready_nxt = 1'b1;
            end
         end
         APPLY: begin
            apply        = 1'b1;
            // The APPLY cycle is itself the first settle cycle.
            lock_cnt_nxt = CNT_W'(LOCK_CYCLES - 1);
            state_nxt    = LOCKING;
         end
         default: begin
            state_nxt = LOCKING;
         end
      endcase
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state     <= LOCKING;
         lock_cnt  <= CNT_W'(LOCK_CYCLES);
         locked    <= 1'b0;
         cfg_ready <= 1'b0;
         lat_ch    <= '0;
         lat_inc   <= '0;
         lat_phase <= '0;
      end else begin
         state     <= state_nxt;
         lock_cnt  <= lock_cnt_nxt;
         locked    <= locked_nxt;
         cfg_ready <= ready_nxt;
         if (latch_en) begin
            lat_ch    <= cfg_ch;
            lat_inc   <= cfg_inc;
            lat_phase <= cfg_phase;
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      vga_nco_ch #(
         .ACC_W       (ACC_W),
         .DEFAULT_INC (DEFAULT_INC)
      ) u_ch (
         .clk        (refclk),
         .rst        (rst),
         .load       (apply && (lat_ch == CHW'(i))),
         .load_inc   (lat_inc),
         .load_phase (lat_phase),
         .strobe     (outclk_en[i]),
         .msb        (outclk[i])
      );
   end

endmodule

// File: tb/tb_vga_clk_ena_gen.sv
// Bench for vga_clk_ena_gen: directed scenarios then random traffic against a timeline/arithmetic model.
module tb_vga_clk_ena_gen;

   localparam int NUM_CH = 3;
   localparam int ACC_W  = 16;
   localparam int LOCK   = 16;
   localparam int CHW    = 2;
   localparam longint DEF_INC = 64'd1 << (ACC_W - 1);

   logic              refclk = 1'b0;
   logic              rst;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CHW-1:0]    cfg_ch;
   logic [ACC_W-1:0]  cfg_inc;
   logic [ACC_W-1:0]  cfg_phase;
   logic [NUM_CH-1:0] outclk_en;
   logic [NUM_CH-1:0] outclk;
   logic              locked;

   vga_clk_ena_gen #(
      .NUM_CH      (NUM_CH),
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_inc   (cfg_inc),
      .cfg_phase (cfg_phase),
      .outclk_en (outclk_en),
      .outclk    (outclk),
      .locked    (locked)
   );

   always #5 refclk = ~refclk;

   int n_cmp = 0;
   int n_bad = 0;
   int ecount = 0;

   // Timeline model: locked holds from edge 'relock' on; cfg_ready dips for one edge after a discarded request.
   int     relock     = 1 << 30;
   int     inv_edge   = -1;
   int     apply_edge = -1;
   int     a_ch;
   longint a_inc, a_phase;
   logic   m_acc;
   // Each channel position after n updates since its base edge is ph0 + n*inc.
   int     base [NUM_CH];
   longint ph0  [NUM_CH];
   longint incm [NUM_CH];

   function automatic logic ready_after(input int e);
      return (e >= relock) && (e != inv_edge);
   endfunction

   function automatic logic exp_en(input int c, input int e);
      longint n, pos, prev;
      n    = e - base[c];
      pos  = ph0[c] + n * incm[c];
      prev = pos - incm[c];
      return (n > 0) && ((pos >> ACC_W) != (prev >> ACC_W));
   endfunction

   function automatic logic exp_clk(input int c, input int e);
      longint pos;
      pos = ph0[c] + longint'(e - base[c]) * incm[c];
      return pos[ACC_W-1];
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, ecount, got, exp);
      end
   endtask

   task automatic step();
      int e;
      logic [NUM_CH-1:0] ee, ec;
      @(posedge refclk);
      ecount++;
      e = ecount;
      m_acc = 1'b0;
      if (rst) begin
         relock     = e + LOCK + 1;
         inv_edge   = -1;
         apply_edge = -1;
         for (int c = 0; c < NUM_CH; c++) begin
            base[c] = e; ph0[c] = 0; incm[c] = DEF_INC;
         end
      end else begin
         if (apply_edge == e) begin
            base[a_ch] = e; ph0[a_ch] = a_phase; incm[a_ch] = a_inc;
         end
         if (cfg_valid && ready_after(e - 1)) begin
            m_acc = 1'b1;
            if (int'(cfg_ch) < NUM_CH) begin
               relock     = e + LOCK + 1;
               apply_edge = e + 1;
               a_ch       = int'(cfg_ch);
               a_inc      = longint'(cfg_inc);
               a_phase    = longint'(cfg_phase);
            end else begin
               inv_edge = e;
            end
         end
      end
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
         ee[c] = exp_en(c, e);
         ec[c] = exp_clk(c, e);
      end
      chk("locked", locked, e >= relock);
      chk("cfg_ready", cfg_ready, ready_after(e));
      chk("outclk_en", outclk_en, ee);
      chk("outclk", outclk, ec);
   endtask

   task automatic cfg_req(input int ch, input logic [ACC_W-1:0] inc, input logic [ACC_W-1:0] phase);
      int k;
      cfg_ch    = CHW'(ch);
      cfg_inc   = inc;
      cfg_phase = phase;
      cfg_valid = 1'b1;
      k = 0;
      do begin
         step();
         k++;
      end while (!m_acc && k < 200);
      cfg_valid = 1'b0;
      if (!m_acc) begin
         n_cmp++;
         n_bad++;
         $error("FAIL cfg_req_timeout ch=%0d got=no_accept exp=accept", ch);
      end
   endtask

   task automatic count_strobes(input int c, input int n, output int cnt);
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         step();
         cnt += int'(outclk_en[c]);
      end
   endtask

   initial begin
      int cnt;
      rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
      repeat (3) step();
      rst = 1'b0;
      repeat (20) step();
      count_strobes(0, 8, cnt);
      chk("t1_ch0_rate", cnt, 4);

      cfg_req(1, 16'h2000, 16'h0000);
      repeat (20) step();
      count_strobes(1, 16, cnt);
      chk("t2_ch1_rate", cnt, 2);

      cfg_req(0, 16'h6000, 16'h0000);
      repeat (20) step();
      count_strobes(0, 8, cnt);
      chk("t3_ch0_3of8_a", cnt, 3);
      count_strobes(0, 8, cnt);
      chk("t3_ch0_3of8_b", cnt, 3);
      cfg_req(1, 16'h0000, 16'h1234);
      repeat (20) step();
      count_strobes(1, 24, cnt);
      chk("t3_ch1_halted", cnt, 0);

      rst = 1'b1;
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 16'h1000; cfg_phase = 16'h4000;
      repeat (2) step();
      rst = 1'b0;
      cfg_req(2, 16'h1000, 16'h4000);
      chk("t4_ready_drop", cfg_ready, 0);
      repeat (20) step();

      cfg_req(3, 16'hffff, 16'hffff);
      chk("t5_locked_kept", locked, 1);
      step();
      chk("t5_ready_back", cfg_ready, 1);
      repeat (4) step();

      cfg_req(2, 16'h0123, 16'h8000);
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (30) step();

      for (int k = 0; k < 1500; k++) begin
         int r;
         rst       = ($urandom_range(0, 299) == 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch    = CHW'($urandom_range(0, 3));
         r = $urandom_range(0, 7);
         cfg_inc   = (r == 0) ? 16'h0000 : (r == 1) ? 16'h8000 : ACC_W'($urandom);
         cfg_phase = ACC_W'($urandom);
         step();
      end
      rst = 1'b0;
      cfg_valid = 1'b0;
      repeat (20) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
